// File: rtl/core_pkg.sv
// Shared core types and constants for the fetch/next-PC path.
// Imported by the sequencer and its next-PC helper.
package core_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2
    } state_t;

    localparam int INSTR_W     = 32;
    localparam int PC_INC      = 4;
    localparam int JR_LINK_REG = 31;

endpackage

// File: rtl/pc_sequencer_npc_calc.sv
// Combinational next-PC selection: jr, jump, taken branch, pc+4.
// Also flags a jr target whose low two bits are nonzero.
module npc_calc
    import core_pkg::*;
(
    input  logic [31:0] pc,
    input  logic [25:0] instr_lo,
    input  logic        jump,
    input  logic        branch,
    input  logic        nequal,
    input  logic        jr,
    input  logic        bclt,
    input  logic        alu_zero,
    input  logic        fp_cond,
    input  logic [31:0] rs_data,
    output logic [31:0] next_pc,
    output logic        misalign
);

    logic [31:0] pc4;
    logic [31:0] br_off;
    logic        taken;

    assign pc4 = pc + 32'(PC_INC);
    assign br_off = {{14{instr_lo[15]}}, instr_lo[15:0], 2'b00};
    assign taken = (branch & (alu_zero ^ nequal))
                 | (bclt & fp_cond);
    assign misalign = jr & (rs_data[1:0] != 2'b00);

    // Several selects may be high at once; the first one wins.
    always_comb begin
        next_pc = pc4;
        priority case (1'b1)
            jr:      next_pc = {rs_data[31:2], 2'b00};
            jump:    next_pc = {pc4[31:28], instr_lo, 2'b00};
            taken:   next_pc = pc4 + br_off;
            default: next_pc = pc4;
        endcase
    end

endmodule

// File: rtl/pc_sequencer.sv
// Instruction fetch FSM and PC/instr/retire state for the MIPS core.
// Next-PC selection is delegated to npc_calc.
module pc_sequencer
    import core_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic               imem_req,
    output logic [31:0]        imem_addr,
    input  logic               imem_ack,
    input  logic [31:0]        imem_rdata,
    output logic [INSTR_W-1:0] instr,
    output logic               instr_valid,
    input  logic               exec_stall,
    input  logic               jump,
    input  logic               branch,
    input  logic               nequal,
    input  logic               jr,
    input  logic               jal,
    input  logic               bclt,
    input  logic               alu_zero,
    input  logic               fp_cond,
    input  logic [31:0]        rs_data,
    output logic [31:0]        link_pc,
    output logic [31:0]        pc,
    output logic [31:0]        retire_cnt,
    output logic               addr_err
);

    state_t      state;
    state_t      state_nx;
    logic        commit;
    logic        fetch_done;
    logic [31:0] next_pc;
    logic        misalign;

    // jal only steers the register-file write, not the fetch path.
    logic unused_jal;
    assign unused_jal = jal;

    assign fetch_done = (state == FETCH) & imem_ack;
    assign commit     = (state == EXEC) & ~exec_stall;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    state_nx = FETCH;
            FETCH:   if (imem_ack) state_nx = EXEC;
            EXEC:    if (!exec_stall) state_nx = FETCH;
            default: state_nx = IDLE;
        endcase
    end

    always_comb begin
        imem_req    = (state == FETCH);
        instr_valid = (state == EXEC);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            instr      <= '0;
            retire_cnt <= '0;
            addr_err   <= 1'b0;
        end else begin
            if (fetch_done) instr <= imem_rdata;
            if (commit) begin
                pc         <= next_pc;
                retire_cnt <= retire_cnt + 32'd1;
                if (misalign) addr_err <= 1'b1;
            end
        end
    end

    assign imem_addr = pc;
    assign link_pc   = pc + 32'(PC_INC);

    npc_calc u_npc (
        .pc       (pc),
        .instr_lo (instr[25:0]),
        .jump     (jump),
        .branch   (branch),
        .nequal   (nequal),
        .jr       (jr),
        .bclt     (bclt),
        .alu_zero (alu_zero),
        .fp_cond  (fp_cond),
        .rs_data  (rs_data),
        .next_pc  (next_pc),
        .misalign (misalign)
    );

endmodule

// File: tb/tb_pc_sequencer.sv
// Self-checking bench for pc_sequencer: directed cases plus random
// instruction streams against a transaction-level next-PC model.
module tb_pc_sequencer;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic [31:0] instr;
    logic        instr_valid;
    logic        exec_stall = 1'b0;
    logic        jump = 0, branch = 0, nequal = 0;
    logic        jr = 0, jal = 0, bclt = 0;
    logic        alu_zero = 0, fp_cond = 0;
    logic [31:0] rs_data = '0;
    logic [31:0] link_pc;
    logic [31:0] pc;
    logic [31:0] retire_cnt;
    logic        addr_err;

    int errs = 0;
    int checks = 0;
    int cyc = 0;

    logic [31:0] m_pc;
    logic [31:0] m_ret;
    logic        m_err;

    pc_sequencer #(.RESET_PC(32'h0)) dut (
        .clk(clk), .rst_n(rst_n),
        .imem_req(imem_req), .imem_addr(imem_addr),
        .imem_ack(imem_ack), .imem_rdata(imem_rdata),
        .instr(instr), .instr_valid(instr_valid),
        .exec_stall(exec_stall),
        .jump(jump), .branch(branch), .nequal(nequal),
        .jr(jr), .jal(jal), .bclt(bclt),
        .alu_zero(alu_zero), .fp_cond(fp_cond),
        .rs_data(rs_data), .link_pc(link_pc), .pc(pc),
        .retire_cnt(retire_cnt), .addr_err(addr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic check(input string tag,
                         input logic [31:0] got,
                         input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errs++;
            $display("FAIL %s: got %h want %h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] model_npc(
        input logic [31:0] p, input logic [31:0] iw,
        input logic [5:0] ctl, input logic az, input logic fc,
        input logic [31:0] rs);
        logic [31:0] p4;
        logic signed [31:0] imm;
        logic tk;
        p4  = p + 4;
        imm = 32'(signed'(iw[15:0]));
        tk  = (ctl[4] && (az != ctl[3])) || (ctl[0] && fc);
        if (ctl[2])      return rs & ~32'd3;
        else if (ctl[5]) return (p4 & 32'hF000_0000) | {4'h0, iw[25:0], 2'b00};
        else if (tk)     return p4 + 32'(imm * 4);
        else             return p4;
    endfunction

    task automatic set_ctl(input logic [5:0] ctl, input logic az,
                           input logic fc, input logic [31:0] rs);
        {jump, branch, nequal, jr, jal, bclt} = ctl;
        alu_zero = az;
        fp_cond  = fc;
        rs_data  = rs;
    endtask

    // ctl = {jump, branch, nequal, jr, jal, bclt}
    task automatic run_instr(input logic [31:0] iw, input int waits,
                             input int stalls, input logic [5:0] ctl,
                             input logic az, input logic fc,
                             input logic [31:0] rs);
        int n;
        logic [31:0] exp_pc;
        n = 0;
        while (!imem_req && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("req_up", {31'd0, imem_req}, 32'd1);
        check("fetch_addr", imem_addr, m_pc);
        for (int w = 0; w < waits; w++) begin
            imem_rdata = $urandom;
            @(negedge clk);
            check("wait_req", {31'd0, imem_req}, 32'd1);
            check("wait_addr", imem_addr, m_pc);
        end
        imem_ack   = 1'b1;
        imem_rdata = iw;
        @(negedge clk);
        imem_ack = 1'b0;
        check("exec_valid", {31'd0, instr_valid}, 32'd1);
        check("exec_instr", instr, iw);
        check("link_pc", link_pc, m_pc + 32'd4);
        for (int s = 0; s < stalls; s++) begin
            exec_stall = 1'b1;
            set_ctl(6'($urandom), 1'($urandom), 1'($urandom), $urandom);
            imem_ack   = 1'($urandom);
            imem_rdata = $urandom;
            @(negedge clk);
            check("stall_pc", pc, m_pc);
            check("stall_instr", instr, iw);
            check("stall_ret", retire_cnt, m_ret);
        end
        imem_ack   = 1'b0;
        exec_stall = 1'b0;
        set_ctl(ctl, az, fc, rs);
        exp_pc = model_npc(m_pc, iw, ctl, az, fc, rs);
        if (ctl[2] && rs[1:0] != 2'b00) m_err = 1'b1;
        m_ret = m_ret + 1;
        m_pc  = exp_pc;
        @(negedge clk);
        set_ctl(6'd0, 1'b0, 1'b0, 32'd0);
        check("commit_pc", pc, m_pc);
        check("retire_cnt", retire_cnt, m_ret);
        check("addr_err", {31'd0, addr_err}, {31'd0, m_err});
        check("post_valid", {31'd0, instr_valid}, 32'd0);
    endtask

    task automatic goto_pc(input logic [31:0] target);
        run_instr(32'h0320_0008, 0, 0, 6'b000100, 0, 0, target);
    endtask

    initial begin
        int c0;
        logic [5:0] rc;
        m_pc = 32'h0; m_ret = 0; m_err = 0;
        repeat (3) @(negedge clk);
        check("rst_req", {31'd0, imem_req}, 32'd0);
        check("rst_valid", {31'd0, instr_valid}, 32'd0);
        check("rst_pc", pc, 32'h0);
        check("rst_instr", instr, 32'h0);
        check("rst_link", link_pc, 32'h4);
        check("rst_ret", retire_cnt, 32'h0);
        check("rst_err", {31'd0, addr_err}, 32'd0);

        // Release just after a falling edge: IDLE cycle, then FETCH.
        rst_n = 1'b1;
        #1 check("idle_req", {31'd0, imem_req}, 32'd0);
        @(negedge clk);
        check("first_req", {31'd0, imem_req}, 32'd1);

        c0 = cyc;
        for (int i = 0; i < 3; i++) run_instr(32'h0, 0, 0, 6'd0, 0, 0, 0);
        check("three_nop_cycles", 32'(cyc - c0), 32'd6);

        goto_pc(32'h100);
        run_instr(32'h1000_FFFE, 0, 0, 6'b010000, 1, 0, 0);
        check("beq_taken", m_pc, 32'hFC);
        check("beq_pc", pc, 32'hFC);
        goto_pc(32'h100);
        run_instr(32'h1400_FFFE, 0, 0, 6'b011000, 1, 0, 0);
        check("bne_pc", pc, 32'h104);

        goto_pc(32'h0040_0010);
        run_instr(32'h0C10_0000, 0, 0, 6'b100010, 0, 0, 0);
        check("jal_pc", pc, 32'h0040_0000);

        goto_pc(32'h203);
        check("jr_mis_pc", pc, 32'h200);
        check("jr_mis_err", {31'd0, addr_err}, 32'd1);
        for (int i = 0; i < 3; i++) run_instr(32'h0, 1, 0, 6'd0, 0, 0, 0);
        check("err_sticky", {31'd0, addr_err}, 32'd1);

        run_instr(32'h0, 3, 2, 6'd0, 0, 0, 0);
        run_instr(32'h4501_0003, 1, 1, 6'b000001, 0, 1, 0);

        goto_pc(32'hFFFF_FFFC);
        run_instr(32'h0, 0, 0, 6'd0, 0, 0, 0);
        check("pc_wrap", pc, 32'h0);

        for (int i = 0; i < 300; i++) begin
            rc = 6'($urandom);
            if ($urandom_range(3) != 0) rc[2] = 1'b0;
            run_instr($urandom, $urandom_range(3), $urandom_range(2),
                      rc, 1'($urandom), 1'($urandom), $urandom);
        end

        // Reset mid-fetch with a stale ack asserted during reset.
        while (!imem_req) @(negedge clk);
        #2 rst_n = 1'b0;
        #1 check("async_req", {31'd0, imem_req}, 32'd0);
        imem_ack = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        repeat (2) @(negedge clk);
        imem_ack = 1'b0;
        rst_n = 1'b1;
        m_pc = 32'h0; m_ret = 0; m_err = 0;
        #1 check("rel_req", {31'd0, imem_req}, 32'd0);
        check("rel_instr", instr, 32'h0);
        check("rel_err", {31'd0, addr_err}, 32'd0);
        @(negedge clk);
        check("refetch_addr", imem_addr, 32'h0);
        run_instr(32'h0, 0, 0, 6'd0, 0, 0, 0);

        $display("Result: errors=%0d of %0d checks", errs, checks);
        $finish;
    end

endmodule
